// File: rtl/gfpd_pkg.sv
// Shared definitions for the Goldschmidt divider operand pre-scaler.
// State encoding and Q8.8 reference constants.
package gfpd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [15:0] Q_ONE    = 16'h0100;
   localparam logic [15:0] Q_TWO    = 16'h0200;
   localparam logic [15:0] RANGE_LO = 16'h0080;
   localparam logic [15:0] RANGE_HI = 16'h00FF;

endpackage

// File: rtl/gfpd_range_cmp.sv
// Classifies a divisor against the normalised window [0.5,1.0).
// Purely combinational; also used by the divider's convergence check.
module gfpd_range_cmp
   import gfpd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] d,
   output logic             too_big,
   output logic             too_small,
   output logic             in_range
);

   assign too_big   = (d > WIDTH'(RANGE_HI));
   assign too_small = (d < WIDTH'(RANGE_LO));
   assign in_range  = !too_big && !too_small;

endmodule

// File: rtl/gfpd_prescaler.sv
// Normalises a Q8.8 dividend/divisor pair one bit per cycle until D' is in [0.5,1.0).
// Build option: define GFPD_PRE_SAT_EN to saturate n_out to all-ones when bits were lost.
module gfpd_prescaler
   import gfpd_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] n_in,
   input  logic [WIDTH-1:0] d_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] n_out,
   output logic [WIDTH-1:0] d_out,
   output logic [WIDTH-1:0] f0_out,
   output logic [SHW-1:0]   shift_out,
   output logic             dz_out,
   output logic             ovf_out
);

   // 2.0 in the operand's fixed-point format; F0 = 2.0 - D'
   localparam logic [WIDTH-1:0] TWO = WIDTH'(1) << (FRAC + 1);

   state_t           state;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH-1:0] d_q;
   logic [SHW-1:0]   shift_q;
   logic             ovf_q;
   logic             too_big;
   logic             too_small;
   logic             in_range;

   gfpd_range_cmp #(.WIDTH(WIDTH)) u_range_cmp (
      .d         (d_q),
      .too_big   (too_big),
      .too_small (too_small),
      .in_range  (in_range)
   );

   assign in_ready = (state == IDLE);

   // NOTE: every register here is plain flop state (no RAM), so all of it is reset;
   // non-blocking assignments keep the FSM and datapath updates edge-consistent.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         n_q       <= '0;
         d_q       <= '0;
         shift_q   <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         n_out     <= '0;
         d_out     <= '0;
         f0_out    <= '0;
         shift_out <= '0;
         dz_out    <= 1'b0;
         ovf_out   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  n_q     <= n_in;
                  d_q     <= d_in;
                  shift_q <= '0;
                  ovf_q   <= 1'b0;
                  if (d_in == '0) begin
                     n_out     <= n_in;
                     d_out     <= '0;
                     f0_out    <= '0;
                     shift_out <= '0;
                     dz_out    <= 1'b1;
                     ovf_out   <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (too_big) begin
                  n_q     <= n_q >> 1;
                  d_q     <= d_q >> 1;
                  shift_q <= shift_q + SHW'(1);
               end else if (too_small) begin
                  n_q     <= n_q << 1;
                  d_q     <= d_q << 1;
                  shift_q <= shift_q - SHW'(1);
                  ovf_q   <= ovf_q | n_q[WIDTH-1];
               end else if (in_range) begin
`ifdef GFPD_PRE_SAT_EN
                  n_out <= ovf_q ? '1 : n_q;
`else
                  n_out <= n_q;
`endif
                  d_out     <= d_q;
                  f0_out    <= TWO - d_q;
                  shift_out <= shift_q;
                  dz_out    <= 1'b0;
                  ovf_out   <= ovf_q;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gfpd_prescaler.sv
// Self-checking bench for gfpd_prescaler: directed corner cases plus random pairs
// compared against an arithmetic normalisation model.
module tb_gfpd_prescaler;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] n_in;
   logic [15:0] d_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] n_out;
   logic [15:0] d_out;
   logic [15:0] f0_out;
   logic [4:0]  shift_out;
   logic        dz_out;
   logic        ovf_out;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [15:0] n;
      logic [15:0] d;
      logic [15:0] f0;
      int          k;
      logic        dz;
      logic        ovf;
      int          lat;
   } exp_t;

   gfpd_prescaler dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .n_in      (n_in),
      .d_in      (d_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .n_out     (n_out),
      .d_out     (d_out),
      .f0_out    (f0_out),
      .shift_out (shift_out),
      .dz_out    (dz_out),
      .ovf_out   (ovf_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scale by powers of two with plain integer arithmetic until 128 <= D < 256.
   function automatic exp_t model(input logic [15:0] n, input logic [15:0] d);
      exp_t        e;
      int unsigned nn;
      int unsigned dd;
      nn    = n;
      dd    = d;
      e.k   = 0;
      e.ovf = 1'b0;
      e.dz  = (d == 16'h0000);
      if (e.dz) begin
         e.n   = n;
         e.d   = 16'h0000;
         e.f0  = 16'h0000;
         e.lat = 0;
         return e;
      end
      while (dd > 255) begin
         nn  = nn / 2;
         dd  = dd / 2;
         e.k = e.k + 1;
      end
      while (dd < 128) begin
         nn  = nn * 2;
         dd  = dd * 2;
         e.k = e.k - 1;
         if (nn > 65535) begin
            e.ovf = 1'b1;
            nn    = nn % 65536;
         end
      end
      e.n  = 16'(nn);
      e.d  = 16'(dd);
      e.f0 = 16'(512 - dd);
`ifdef GFPD_PRE_SAT_EN
      if (e.ovf) e.n = 16'hFFFF;
`endif
      e.lat = ((e.k < 0) ? -e.k : e.k) + 1;
      return e;
   endfunction

   task automatic check_result(input string tag, input exp_t e);
      logic [4:0] ek;
      ek = e.k[4:0];
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".n"}, 32'(n_out), 32'(e.n));
      check({tag, ".d"}, 32'(d_out), 32'(e.d));
      check({tag, ".f0"}, 32'(f0_out), 32'(e.f0));
      check({tag, ".shift"}, 32'(shift_out), 32'(ek));
      check({tag, ".dz"}, 32'(dz_out), 32'(e.dz));
      check({tag, ".ovf"}, 32'(ovf_out), 32'(e.ovf));
      check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
   endtask

   // One full transaction: offer, wait for result (bounded), hold off, then drain.
   task automatic run_op(input string tag, input logic [15:0] n, input logic [15:0] d,
                         input int hold);
      exp_t e;
      int   lat;
      e = model(n, d);
      @(negedge clk);
      n_in     = n;
      d_in     = d;
      in_valid = 1'b1;
      check({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      // Keep in_valid high with junk operands; they must be ignored until IDLE.
      n_in = 16'($urandom);
      d_in = 16'($urandom);
      lat  = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(e.lat));
      check_result(tag, e);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_result({tag, ".hold"}, e);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, ".valid"}, 32'(out_valid), 32'd0);
      check({tag, ".outs"}, {n_out, d_out}, 32'd0);
      check({tag, ".f0"}, 32'(f0_out), 32'd0);
      check({tag, ".flags"}, {25'd0, shift_out, dz_out, ovf_out}, 32'd0);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] rn;
      logic [15:0] rd;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_in      = 16'h0000;
      d_in      = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check_cleared("reset");
      @(negedge clk);
      reset = 1'b1;

      run_op("t1", 16'h0100, 16'h0200, 0);
      run_op("t2", 16'h0100, 16'h0280, 1);
      run_op("t3", 16'h0100, 16'h0040, 0);
      run_op("t4_dz", 16'h1234, 16'h0000, 2);
      run_op("t5_ovf", 16'h4000, 16'h0001, 0);
      run_op("max_right", 16'hFFFF, 16'hFFFF, 0);
      run_op("lo_edge", 16'h0055, 16'h0080, 0);
      run_op("hi_edge", 16'h0055, 16'h00FF, 0);
      run_op("stall", 16'h0321, 16'h0007, 5);

      // Abort mid-SHIFT with an asynchronous reset pulse.
      @(negedge clk);
      n_in     = 16'h4000;
      d_in     = 16'h0001;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_cleared("abort");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_cleared("abort_idle");
      run_op("after_abort", 16'h0100, 16'h0200, 0);

      for (int i = 0; i < 40; i++) begin
         rn = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       rd = 16'h0000;
            1:       rd = 16'($urandom_range(1, 127));
            2:       rd = 16'($urandom_range(128, 255));
            default: rd = 16'($urandom);
         endcase
         run_op("rand", rn, rd, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
